line_trig_ctrl: RTL and testbench

//  Line-scan trigger scheduler. Brings the asynchronous external line trigger into the CLK domain

---
 rtl/line_trig_ctrl_pkg.sv | 14 +
 rtl/reg_sync.sv | 25 ++
 rtl/trig_filter.sv | 35 +++
 rtl/line_trig_ctrl.sv | 162 ++++++++++++++++
 tb/tb_line_trig_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/line_trig_ctrl_pkg.sv
// Shared constants for the line trigger scheduler: FSM state encodings and default widths.
package line_trig_ctrl_pkg;

    localparam int DEF_CNT_W    = 16;
    localparam int DEF_LCNT_W   = 32;
    localparam int DEF_OCNT_W   = 16;
    localparam int DEF_FILT_LEN = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DELAY   = 2'd1;
    localparam logic [1:0] ST_EXPOSE  = 2'd2;
    localparam logic [1:0] ST_HOLDOFF = 2'd3;

endpackage

// File: rtl/reg_sync.sv
// Multi-stage flop synchronizer for bringing asynchronous levels into the CLK domain.
module reg_sync #(
    parameter int               WIDTH  = 1,
    parameter logic [WIDTH-1:0] INIT   = '0,
    parameter int               STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stage_reg <= {STAGES{INIT}};
        end else begin
            stage_reg <= {stage_reg[STAGES-2:0], d};
        end
    end

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/trig_filter.sv
// Glitch filter: the output follows the input only after the input has held a new value
// for FILT_LEN consecutive cycles.
module trig_filter #(
    parameter int   FILT_LEN = 4,
    parameter logic INIT     = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic dout
);

    localparam int            CW   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

    logic [CW-1:0] run_reg;
    logic          out_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_reg <= INIT;
            run_reg <= '0;
        end else if (din == out_reg) begin
            run_reg <= '0;
        end else if (run_reg == LAST) begin
            out_reg <= din;
            run_reg <= '0;
        end else begin
            run_reg <= run_reg + CW'(1);
        end
    end

    assign dout = out_reg;

endmodule

// File: rtl/line_trig_ctrl.sv
// Line-scan trigger scheduler: sync/edge-detect the external trigger, merge with SW_TRIG and run
// each line through delay, exposure and holdoff. Define LINE_TRIG_FILTER_EN to add the glitch filter.
module line_trig_ctrl
    import line_trig_ctrl_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int LCNT_W   = DEF_LCNT_W,
    parameter int OCNT_W   = DEF_OCNT_W,
    parameter int FILT_LEN = DEF_FILT_LEN
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EXT_TRIG,
    input  logic              SW_TRIG,
    input  logic              ENABLE,
    input  logic              CLR_CNT,
    input  logic [CNT_W-1:0]  DELAY_CFG,
    input  logic [CNT_W-1:0]  EXPO_CFG,
    input  logic [CNT_W-1:0]  HOLDOFF_CFG,
    output logic              LINE_START,
    output logic              LINE_ACTIVE,
    output logic              BUSY,
    output logic              OVERRUN,
    output logic [LCNT_W-1:0] LINE_CNT,
    output logic [OCNT_W-1:0] OVR_CNT
);

    if (FILT_LEN < 1) begin : g_bad_filt_len
        $error("line_trig_ctrl: FILT_LEN must be >= 1");
    end

    logic              trig_s;
    logic              trig_f;
    logic              trig_r_reg;
    logic              trig_rise;
    logic              trig_evt;
    logic              busy;
    logic [1:0]        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CNT_W-1:0]  expo_reg;
    logic [CNT_W-1:0]  hold_reg;
    logic              line_start_reg;
    logic              overrun_reg;
    logic [LCNT_W-1:0] line_cnt_reg;
    logic [OCNT_W-1:0] ovr_cnt_reg;

    // Synchronizer idles high so a trigger held through reset never looks like a rising edge.
    reg_sync #(
        .WIDTH  (1),
        .INIT   (1'b1),
        .STAGES (2)
    ) u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (EXT_TRIG),
        .q   (trig_s)
    );

`ifdef LINE_TRIG_FILTER_EN
    trig_filter #(
        .FILT_LEN (FILT_LEN),
        .INIT     (1'b1)
    ) u_filter (
        .CLK  (CLK),
        .RST  (RST),
        .din  (trig_s),
        .dout (trig_f)
    );
`else
    assign trig_f = trig_s;
`endif

    assign trig_rise = trig_f & ~trig_r_reg;
    assign trig_evt  = (trig_rise | SW_TRIG) & ENABLE;
    assign busy      = (state_reg != ST_IDLE);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (trig_evt) begin
                    state_next = ST_DELAY;
                    cnt_next   = DELAY_CFG;
                end
            end
            ST_DELAY: begin
                if (cnt_reg == '0) begin
                    state_next = ST_EXPOSE;
                    // A zero exposure still produces a one-cycle line.
                    cnt_next   = (expo_reg == '0) ? '0 : expo_reg - CNT_W'(1);
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_EXPOSE: begin
                if (cnt_reg == '0) begin
                    if (hold_reg == '0) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_HOLDOFF;
                        cnt_next   = hold_reg - CNT_W'(1);
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            expo_reg       <= '0;
            hold_reg       <= '0;
            trig_r_reg     <= 1'b1;
            line_start_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            trig_r_reg     <= trig_f;
            line_start_reg <= (state_reg == ST_DELAY) && (cnt_reg == '0);
            overrun_reg    <= trig_evt && busy;
            if ((state_reg == ST_IDLE) && trig_evt) begin
                expo_reg <= EXPO_CFG;
                hold_reg <= HOLDOFF_CFG;
            end
        end
    end

    // A clear beats any increment landing in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST || CLR_CNT) begin
            line_cnt_reg <= '0;
            ovr_cnt_reg  <= '0;
        end else begin
            if (line_start_reg) begin
                line_cnt_reg <= line_cnt_reg + LCNT_W'(1);
            end
            if (trig_evt && busy && (ovr_cnt_reg != '1)) begin
                ovr_cnt_reg <= ovr_cnt_reg + OCNT_W'(1);
            end
        end
    end

    assign LINE_START  = line_start_reg;
    assign LINE_ACTIVE = (state_reg == ST_EXPOSE);
    assign BUSY        = busy;
    assign OVERRUN     = overrun_reg;
    assign LINE_CNT    = line_cnt_reg;
    assign OVR_CNT     = ovr_cnt_reg;

endmodule

// File: tb/tb_line_trig_ctrl.sv
// Scoreboard bench for line_trig_ctrl: predicted line starts, line lengths, busy spans and
// overrun pulses are queued at stimulus time and matched by a negedge monitor.
module tb_line_trig_ctrl;

    localparam int CNT_W    = 16;
    localparam int LCNT_W   = 32;
    localparam int OCNT_W   = 8;
    localparam int FILT_LEN = 4;
    localparam int OVR_MAX  = (1 << OCNT_W) - 1;
`ifdef LINE_TRIG_FILTER_EN
    localparam int FX = FILT_LEN;
`else
    localparam int FX = 0;
`endif

    logic              CLK;
    logic              RST;
    logic              EXT_TRIG;
    logic              SW_TRIG;
    logic              ENABLE;
    logic              CLR_CNT;
    logic [CNT_W-1:0]  DELAY_CFG;
    logic [CNT_W-1:0]  EXPO_CFG;
    logic [CNT_W-1:0]  HOLDOFF_CFG;
    logic              LINE_START;
    logic              LINE_ACTIVE;
    logic              BUSY;
    logic              OVERRUN;
    logic [LCNT_W-1:0] LINE_CNT;
    logic [OCNT_W-1:0] OVR_CNT;

    line_trig_ctrl #(
        .CNT_W    (CNT_W),
        .LCNT_W   (LCNT_W),
        .OCNT_W   (OCNT_W),
        .FILT_LEN (FILT_LEN)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .EXT_TRIG    (EXT_TRIG),
        .SW_TRIG     (SW_TRIG),
        .ENABLE      (ENABLE),
        .CLR_CNT     (CLR_CNT),
        .DELAY_CFG   (DELAY_CFG),
        .EXPO_CFG    (EXPO_CFG),
        .HOLDOFF_CFG (HOLDOFF_CFG),
        .LINE_START  (LINE_START),
        .LINE_ACTIVE (LINE_ACTIVE),
        .BUSY        (BUSY),
        .OVERRUN     (OVERRUN),
        .LINE_CNT    (LINE_CNT),
        .OVR_CNT     (OVR_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_lines = 0;
    int exp_ovr   = 0;
    int exp_start_q[$];
    int exp_len_q[$];
    int exp_busy_q[$];
    int exp_ovr_q[$];

    int act_run  = 0;
    int busy_run = 0;
    int cur_len  = 0;
    int cur_busy = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic set_cfg(input int d, input int e, input int h);
        DELAY_CFG   = CNT_W'(d);
        EXPO_CFG    = CNT_W'(e);
        HOLDOFF_CFG = CNT_W'(h);
    endtask

    // lat: trigger-to-LINE_START latency excluding the programmed delay
    task automatic push_line(input int d, input int e, input int h, input int lat);
        int el;
        el = (e == 0) ? 1 : e;
        exp_start_q.push_back(cyc + lat + d);
        exp_len_q.push_back(el);
        exp_busy_q.push_back(d + 1 + el + h);
        exp_lines++;
    endtask

    task automatic push_ovr();
        exp_ovr_q.push_back(cyc + 1);
        if (exp_ovr < OVR_MAX) exp_ovr++;
    endtask

    task automatic sw_pulse();
        SW_TRIG = 1'b1;
        tick(1);
        SW_TRIG = 1'b0;
    endtask

    task automatic sw_line(input int d, input int e, input int h);
        set_cfg(d, e, h);
        push_line(d, e, h, 2);
        sw_pulse();
    endtask

    task automatic wait_idle(input string tag);
        tick(6 + FX);
        for (int i = 0; i < 600 && BUSY; i++) tick(1);
        check(tag, 64'(BUSY), 64'(0));
        tick(1);
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_line_cnt"}, 64'(LINE_CNT), 64'(exp_lines));
        check({tag, "_ovr_cnt"}, 64'(OVR_CNT), 64'(exp_ovr));
    endtask

    initial begin
        int e;
        forever begin
            @(negedge CLK);
            if (RST) begin
                act_run  = 0;
                busy_run = 0;
            end else begin
                if (LINE_START) begin
                    check("start_expected", 64'(LINE_START), 64'(exp_start_q.size() > 0));
                    if (exp_start_q.size() > 0) begin
                        e       = exp_start_q.pop_front();
                        cur_len = exp_len_q.pop_front();
                        $display("txn line_start cyc=%0d exp_cyc=%0d exp_len=%0d", cyc, e, cur_len);
                        check("start_cyc", 64'(cyc), 64'(e));
                    end
                end
                if (LINE_ACTIVE) begin
                    act_run++;
                end else if (act_run != 0) begin
                    check("active_len", 64'(act_run), 64'(cur_len));
                    act_run = 0;
                end
                if (BUSY) begin
                    if (busy_run == 0) begin
                        check("busy_expected", 64'(BUSY), 64'(exp_busy_q.size() > 0));
                        cur_busy = (exp_busy_q.size() > 0) ? exp_busy_q.pop_front() : 0;
                    end
                    busy_run++;
                end else if (busy_run != 0) begin
                    check("busy_len", 64'(busy_run), 64'(cur_busy));
                    busy_run = 0;
                end
                if (OVERRUN) begin
                    check("ovr_expected", 64'(OVERRUN), 64'(exp_ovr_q.size() > 0));
                    if (exp_ovr_q.size() > 0) begin
                        e = exp_ovr_q.pop_front();
                        $display("txn overrun cyc=%0d exp_cyc=%0d ovr_cnt=%0d", cyc, e, OVR_CNT);
                        check("ovr_cyc", 64'(cyc), 64'(e));
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        RST = 1'b1; EXT_TRIG = 1'b0; SW_TRIG = 1'b0; ENABLE = 1'b1; CLR_CNT = 1'b0;
        set_cfg(0, 0, 0);
        tick(3);
        check("rst_line_start", 64'(LINE_START), 64'(0));
        check("rst_line_active", 64'(LINE_ACTIVE), 64'(0));
        check("rst_busy", 64'(BUSY), 64'(0));
        check("rst_overrun", 64'(OVERRUN), 64'(0));
        check_cnts("rst");
        RST = 1'b0;
        tick(4);

        // External trigger, delay 3 / expo 5 / holdoff 2; config changed after acceptance
        set_cfg(3, 5, 2);
        push_line(3, 5, 2, 4 + FX);
        EXT_TRIG = 1'b1;
        tick(4 + FX);
        set_cfg(1, 9, 7);
        wait_idle("t1_idle");
        check_cnts("t1");
        EXT_TRIG = 1'b0;
        tick(3);

        // Software triggers during EXPOSE and HOLDOFF are dropped
        k = cyc;
        sw_line(3, 5, 2);
        tick_to(k + 6);
        push_ovr();
        sw_pulse();
        tick_to(k + 10);
        push_ovr();
        sw_pulse();
        wait_idle("t2_idle");
        check_cnts("t2");

        // 3-cycle external pulse: rejected by the filter, a line without it
        set_cfg(1, 2, 1);
`ifndef LINE_TRIG_FILTER_EN
        push_line(1, 2, 1, 4);
`endif
        EXT_TRIG = 1'b1;
        tick(3);
        EXT_TRIG = 1'b0;
        wait_idle("t3a_idle");
        tick(FX + 4);
        check_cnts("t3a");
        push_line(1, 2, 1, 4 + FX);
        EXT_TRIG = 1'b1;
        tick(4);
        EXT_TRIG = 1'b0;
        wait_idle("t3b_idle");
        tick(FX + 4);
        check_cnts("t3b");

        // Zero delay/expo/holdoff, back-to-back software triggers every 4 cycles
        for (int i = 0; i < 4; i++) begin
            sw_line(0, 0, 0);
            tick(3);
        end
        wait_idle("t4_idle");
        check_cnts("t4");

        // Trigger held high through reset must not fire
        EXT_TRIG = 1'b1;
        RST = 1'b1;
        tick(3);
        RST = 1'b0;
        exp_lines = 0;
        exp_ovr   = 0;
        tick(10 + FX);
        check("t5_busy", 64'(BUSY), 64'(0));
        check_cnts("t5a");
        EXT_TRIG = 1'b0;
        tick(4 + FX);

        // ENABLE low: edges and software triggers ignored, no overrun
        ENABLE = 1'b0;
        EXT_TRIG = 1'b1;
        tick(6 + FX);
        EXT_TRIG = 1'b0;
        sw_pulse();
        tick(8 + FX);
        check("t5_busy_dis", 64'(BUSY), 64'(0));
        check_cnts("t5b");
        ENABLE = 1'b1;

        // ENABLE dropped mid-line: the line completes, the trigger is ignored
        sw_line(2, 6, 1);
        tick(4);
        ENABLE = 1'b0;
        sw_pulse();
        ENABLE = 1'b1;
        wait_idle("t5c_idle");
        check_cnts("t5c");

        // Rising edge and SW_TRIG in the same cycle make one event
        set_cfg(1, 1, 1);
        k = cyc;
        push_line(1, 1, 1, 4 + FX);
        EXT_TRIG = 1'b1;
        tick_to(k + 2 + FX);
        sw_pulse();
        wait_idle("t7_idle");
        EXT_TRIG = 1'b0;
        tick(4 + FX);
        check_cnts("t7");

        // Reset mid-exposure clears everything on the next cycle
        k = cyc;
        sw_line(0, 20, 0);
        tick_to(k + 5);
        RST = 1'b1;
        tick(1);
        check("t6_active", 64'(LINE_ACTIVE), 64'(0));
        check("t6_busy", 64'(BUSY), 64'(0));
        check("t6_start", 64'(LINE_START), 64'(0));
        check("t6_overrun", 64'(OVERRUN), 64'(0));
        check("t6_line_cnt", 64'(LINE_CNT), 64'(0));
        RST = 1'b0;
        exp_lines = 0;
        exp_ovr   = 0;
        tick(4);

        // Overrun counter saturates; OVERRUN keeps pulsing
        sw_line(0, 300, 0);
        SW_TRIG = 1'b1;
        for (int i = 0; i < OVR_MAX + 5; i++) begin
            push_ovr();
            tick(1);
        end
        SW_TRIG = 1'b0;
        tick(1);
        check("t6_ovr_sat", 64'(OVR_CNT), 64'(OVR_MAX));
        wait_idle("t6c_idle");
        check_cnts("t6c");

        // CLR_CNT on the LINE_START cycle wins over the increment
        k = cyc;
        sw_line(2, 3, 0);
        tick_to(k + 4);
        CLR_CNT = 1'b1;
        tick(1);
        CLR_CNT = 1'b0;
        exp_lines = 0;
        exp_ovr   = 0;
        wait_idle("t6b_idle");
        check_cnts("t6b");

        tick(5);
        check("left_start_q", 64'(exp_start_q.size()), 64'(0));
        check("left_busy_q", 64'(exp_busy_q.size()), 64'(0));
        check("left_ovr_q", 64'(exp_ovr_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
